// File: rtl/spi_cmd_slave.sv
// SPI command slave: synchronized companion-MCU SPI bus decoded into config writes,
// channel enables, a status read and a little-endian word stream with valid/ready handshake.
module spi_cmd_slave #(
    parameter int NUM_CFG = 2,
    parameter int NUM_CH  = 2,
    parameter int DW      = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sspi_cs,
    input  logic                   sspi_clk,
    input  logic                   sspi_mosi,
    output logic                   sspi_miso,
    output logic [32*NUM_CFG-1:0]  cfg,
    output logic [NUM_CH-1:0]      load_active,
    output logic [CH_W-1:0]        load_ch,
    output logic [DW-1:0]          load_data,
    output logic                   load_last,
    output logic                   load_valid,
    input  logic                   load_ready,
    output logic                   err_overrun,
    output logic                   err_cmd
);
    localparam int LANES  = DW / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [7:0] NUM_CFG_B = 8'(NUM_CFG);
    localparam logic [7:0] NUM_CH_B  = 8'(NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARGS, S_DATA, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cs_s_q, cs_s_d, sclk_s_q, sclk_s_d, mosi_s_q, mosi_s_d;
    logic                 sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d, arg_cnt_q, arg_cnt_d;
    logic [6:0]           sh_q, sh_d;
    logic [7:0]           cmd_q, cmd_d, idx_q, idx_d, snap_q, snap_d;
    logic [23:0]          arg_sh_q, arg_sh_d, len_q, len_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [DW-1:0]        pack_q, pack_d;
    logic                 status_rd_q, status_rd_d;
    logic [32*NUM_CFG-1:0] cfg_q, cfg_d;
    logic [NUM_CH-1:0]    act_q, act_d;
    logic                 lv_q, lv_d, llast_q, llast_d;
    logic [CH_W-1:0]      lch_q, lch_d;
    logic [DW-1:0]        ldata_q, ldata_d;
    logic                 eovr_q, eovr_d, ecmd_q, ecmd_d, miso_q, miso_d;

    logic                 cs_hi, cs_rise, sclk_rise, sclk_fall, byte_done;
    logic [7:0]           rx_byte, status_now;
    logic [3:0]           act4;
    logic                 word_emit, word_last, ecmd_set, eovr_set;
    logic [DW-1:0]        word_data;

    always_comb begin
        state_d     = state_q;
        cs_s_d      = {cs_s_q[0], sspi_cs};
        sclk_s_d    = {sclk_s_q[0], sspi_clk};
        mosi_s_d    = {mosi_s_q[0], sspi_mosi};
        sclk_prev_d = sclk_s_q[1];
        cs_prev_d   = cs_s_q[1];
        bit_cnt_d   = bit_cnt_q;
        arg_cnt_d   = arg_cnt_q;
        sh_d        = sh_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        arg_sh_d    = arg_sh_q;
        len_d       = len_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        status_rd_d = status_rd_q;
        cfg_d       = cfg_q;
        act_d       = act_q;
        lv_d        = lv_q;
        llast_d     = llast_q;
        lch_d       = lch_q;
        ldata_d     = ldata_q;
        miso_d      = miso_q;

        cs_hi      = cs_s_q[1];
        cs_rise    = cs_hi & ~cs_prev_q;
        sclk_rise  = sclk_s_q[1] & ~sclk_prev_q;
        sclk_fall  = ~sclk_s_q[1] & sclk_prev_q;
        rx_byte    = {sh_q, mosi_s_q[1]};
        byte_done  = 1'b0;
        word_emit  = 1'b0;
        word_last  = 1'b0;
        word_data  = '0;
        ecmd_set   = 1'b0;
        eovr_set   = 1'b0;
        act4       = '0;
        act4[NUM_CH-1:0] = act_q;
        status_now = {eovr_q, ecmd_q, 2'b00, act4};

        if (lv_q && load_ready) lv_d = 1'b0;

        if (cs_hi) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            arg_cnt_d   = '0;
            lane_d      = '0;
            pack_d      = '0;
            len_d       = '0;
            sh_d        = '0;
            miso_d      = 1'b0;
            status_rd_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (cs_prev_q) state_d = S_CMD;
        end else begin
            if (sclk_rise) begin
                sh_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                byte_done = (bit_cnt_q == 3'd7);
            end
            if (sclk_fall)
                miso_d = (state_q == S_DATA && cmd_q == 8'h01) ? snap_q[3'd7 - bit_cnt_q] : 1'b0;
            if (byte_done) begin
                case (state_q)
                    S_CMD: begin
                        cmd_d     = rx_byte;
                        snap_d    = status_now;
                        arg_cnt_d = '0;
                        case (rx_byte)
                            8'h01: begin
                                state_d = S_DATA;
                                miso_d  = status_now[7];
                            end
                            8'h02, 8'h06, 8'h07: state_d = S_ARGS;
                            default: begin
                                ecmd_set = 1'b1;
                                state_d  = S_DONE;
                            end
                        endcase
                    end
                    S_ARGS: begin
                        arg_cnt_d = arg_cnt_q + 3'd1;
                        arg_sh_d  = {arg_sh_q[15:0], rx_byte};
                        if (arg_cnt_q == 3'd0) begin
                            idx_d = rx_byte;
                            if ((cmd_q == 8'h02) ? (rx_byte >= NUM_CFG_B) : (rx_byte >= NUM_CH_B)) begin
                                ecmd_set = 1'b1;
                                state_d  = S_DONE;
                            end
                        end else if (cmd_q == 8'h02 && arg_cnt_q == 3'd4) begin
                            for (int i = 0; i < NUM_CFG; i++)
                                if (idx_q == 8'(i)) cfg_d[32*i +: 32] = {arg_sh_q, rx_byte};
                            state_d = S_DONE;
                        end else if (cmd_q == 8'h06 && arg_cnt_q == 3'd1) begin
                            for (int i = 0; i < NUM_CH; i++)
                                if (idx_q == 8'(i)) act_d[i] = rx_byte[0];
                            state_d = S_DONE;
                        end else if (cmd_q == 8'h07 && arg_cnt_q == 3'd3) begin
                            len_d   = {arg_sh_q[15:0], rx_byte};
                            lane_d  = '0;
                            pack_d  = '0;
                            state_d = ({arg_sh_q[15:0], rx_byte} == 24'd0) ? S_DONE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (cmd_q == 8'h01) begin
                            status_rd_d = 1'b1;
                            state_d     = S_DONE;
                        end else if (len_q != 24'd0) begin
                            for (int l = 0; l < LANES; l++)
                                if (lane_q == LANE_W'(l)) pack_d[8*l +: 8] = rx_byte;
                            len_d = len_q - 24'd1;
                            if (lane_q == LANE_W'(LANES - 1) || len_q == 24'd1) begin
                                word_emit = 1'b1;
                                word_last = (len_q == 24'd1);
                                word_data = pack_d;
                                lane_d    = '0;
                                pack_d    = '0;
                            end else begin
                                lane_d = lane_q + 1'b1;
                            end
                            if (len_q == 24'd1) state_d = S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // A held, unaccepted word is never overwritten; the newcomer is dropped.
        if (word_emit) begin
            if (lv_q && !load_ready) begin
                eovr_set = 1'b1;
            end else begin
                lv_d    = 1'b1;
                ldata_d = word_data;
                llast_d = word_last;
                lch_d   = idx_q[CH_W-1:0];
            end
        end

        eovr_d = eovr_set ? 1'b1 : ((cs_rise && status_rd_q) ? 1'b0 : eovr_q);
        ecmd_d = ecmd_set ? 1'b1 : ((cs_rise && status_rd_q) ? 1'b0 : ecmd_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cs_s_q      <= '0;
            sclk_s_q    <= '0;
            mosi_s_q    <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            arg_cnt_q   <= '0;
            sh_q        <= '0;
            cmd_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            arg_sh_q    <= '0;
            len_q       <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            status_rd_q <= 1'b0;
            cfg_q       <= '0;
            act_q       <= '0;
            lv_q        <= 1'b0;
            llast_q     <= 1'b0;
            lch_q       <= '0;
            ldata_q     <= '0;
            eovr_q      <= 1'b0;
            ecmd_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_s_q      <= cs_s_d;
            sclk_s_q    <= sclk_s_d;
            mosi_s_q    <= mosi_s_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            arg_cnt_q   <= arg_cnt_d;
            sh_q        <= sh_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            arg_sh_q    <= arg_sh_d;
            len_q       <= len_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            status_rd_q <= status_rd_d;
            cfg_q       <= cfg_d;
            act_q       <= act_d;
            lv_q        <= lv_d;
            llast_q     <= llast_d;
            lch_q       <= lch_d;
            ldata_q     <= ldata_d;
            eovr_q      <= eovr_d;
            ecmd_q      <= ecmd_d;
            miso_q      <= miso_d;
        end
    end

    assign sspi_miso   = miso_q;
    assign cfg         = cfg_q;
    assign load_active = act_q;
    assign load_ch     = lch_q;
    assign load_data   = ldata_q;
    assign load_last   = llast_q;
    assign load_valid  = lv_q;
    assign err_overrun = eovr_q;
    assign err_cmd     = ecmd_q;
endmodule

// File: doc/spi_cmd_slave.md
SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 Parameter NUM_CFG, default 2: number of 32-bit core config registers, legal range 1..8.
REQ-002 Parameter NUM_CH, default 2: number of load channels, legal range 1..4; CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter DW, default 16: load word width, legal values 8, 16, 32.
REQ-004 clk  in  1: single clock for all logic.
REQ-005 resetn  in  1: reset, asynchronous and active-low.
REQ-006 sspi_cs, sspi_clk, sspi_mosi  in  1 each: companion-MCU SPI (mode 0, MSB-first, cs active-low), asynchronous to clk.
REQ-007 sspi_miso  out  1: SPI read data.
REQ-008 cfg  out  32*NUM_CFG: config registers; register i occupies bits [32i+31:32i].
REQ-009 load_active  out  NUM_CH: per-channel loading flag.
REQ-010 load_ch  out  CH_W, load_data  out  DW, load_last  out  1: load word, its channel, and the final-word flag.
REQ-011 load_valid  out  1 / load_ready  in  1: word handshake.
REQ-012 err_overrun, err_cmd  out  1 each: sticky error flags.

Function
REQ-013 cs, sclk and mosi SHALL each pass through a 2-FF synchronizer; a sclk rising edge is detected on synchronized 0->1; sclk SHALL be at most clk/4.
REQ-014 While cs is high: bit counter = 0, byte counter = 0, state = IDLE. cfg, load_active and the error flags SHALL be retained.
REQ-015 Bits SHALL be shifted in on each detected rising edge, MSB-first; a byte completes on the 8th bit.
REQ-016 The FSM SHALL have states IDLE -> CMD -> ARGS -> (DATA | DONE). IDLE moves to CMD when cs falls. The first byte is latched as the command.
REQ-017 Cmd 0x01 (status): the next byte on MISO SHALL be {err_overrun, err_cmd, 2'b0, load_active zero-extended to 4 bits}, snapshotted when the command byte completes. Both error flags SHALL clear when cs rises after at least one full status byte has been shifted.
REQ-018 Cmd 0x02 idx[7:0] d[31:0]: cfg[idx] <= d, updated in the cycle the 5th byte completes. If idx >= NUM_CFG, no write occurs and err_cmd is set.
REQ-019 Cmd 0x06 ch[7:0] s[7:0]: load_active[ch] <= s[0]. If ch >= NUM_CH, err_cmd is set.
REQ-020 Cmd 0x07 ch[7:0] len[23:0] then len data bytes:
- Bytes are packed little-endian into DW-bit words: the first byte goes to load_data[7:0].
- A word is emitted when DW/8 bytes have been collected, or on the final byte. Unfilled lanes are zero, and load_last = 1 on the final word.
- len = 0: no words are emitted.
- Bytes beyond len, and bytes after cs rises, SHALL be ignored.
- ch >= NUM_CH: err_cmd is set and the data is discarded.
REQ-021 Any other command byte SHALL set err_cmd; the remaining bytes until cs rises SHALL be ignored.
REQ-022 Handshake: load_valid rises 1 cycle after the completing byte. load_ch, load_data and load_last SHALL be held stable until the cycle in which load_valid && load_ready; load_valid drops in the following cycle unless a new word is pending.
REQ-023 If a word completes while a previous word is still unaccepted, the new word SHALL be dropped and err_overrun set; the held word is not modified.
REQ-024 cs rises mid cmd 0x07: a partially packed word SHALL be discarded, not emitted; load_active is unchanged.
REQ-025 A length counter reaching 0 SHALL NOT wrap; the 24-bit length range is 0..16,777,215.
REQ-026 MISO output:
- sspi_miso = status_snapshot[7 - bit_cnt] only during the status data byte of cmd 0x01; otherwise 0.
- It changes only on detected sclk falling edges or on entry to the status byte.
REQ-027 Simultaneous error set and clear-on-cs-rise: set SHALL win.

Reset
REQ-028 On resetn low: cfg = 0, load_active = 0, load_valid = 0, load_data = 0, load_ch = 0, load_last = 0, err_overrun = 0, err_cmd = 0, sspi_miso = 0, FSM = IDLE, all counters = 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer. After resetn releases, the next transaction SHALL begin cleanly at the first cs falling edge.

Verification
REQ-030 Cmd 0x02 idx=1 d=0xDEADBEEF -> cfg[63:32] = 0xDEADBEEF, cfg[31:0] unchanged. Cmd 0x02 idx=5 -> no write and err_cmd = 1.
REQ-031 DW=16, cmd 0x07 ch=1 len=5 with bytes 11 22 33 44 55, load_ready = 1 -> words 0x2211, 0x4433, 0x0055 on load_ch=1; load_last only on 0x0055.
REQ-032 Same as REQ-031 but load_ready = 0 throughout -> load_data stays 0x2211, the other words are dropped, err_overrun = 1.
REQ-033 Cmd 0x06 ch=0 s=1, then cmd 0x01 -> MISO byte 0x01. Repeat cmd 0x01 after err_cmd was set -> 0x41 first, then 0x01 on the following read.
REQ-034 cs rises after 3 of 4 data bytes (DW=32) -> no load_valid, and the next command decodes correctly.
REQ-035 resetn pulsed low mid cmd 0x07 -> all outputs take their REQ-028 values asynchronously, with no spurious load_valid.
